// File: rtl/save_state_ctrl_pkg.sv
// Shared save-state definitions: controller FSM/op encodings and slot/memory sizing defaults.
package save_state_ctrl_pkg;

  localparam int NUM_SLOTS_DEF          = 4;
  localparam int SLOT_BITS_DEF          = 2;
  localparam int SAVE_STATE_BITS        = 16;
  localparam int SAVE_STATE_LAST_ADDRESS = (1 << SAVE_STATE_BITS) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ISSUE,
    ST_WAIT_DONE
  } ctrl_state_e;

  typedef enum logic {
    OP_SAVE,
    OP_LOAD
  } op_e;

endpackage

// File: rtl/save_state_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle pulse on committed rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;

  // Counter only runs while the synchronized level disagrees with the committed one,
  // so any bounce back to the committed level restarts the stability window.
  always_comb begin
    sync_d = {sync_q[0], btn};
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      lvl_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    req_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
    end
  end

  assign req = req_q;

endmodule

// File: rtl/save_state_ctrl.sv
// Save/load front-end: debounced requests, frame-aligned begin pulse, completion/timeout tracking.
module save_state_ctrl
  import save_state_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
  parameter int SLOT_BITS       = SLOT_BITS_DEF,
  parameter int TIMEOUT_CYCLES  = 131072
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 save_btn,
  input  logic                 load_btn,
  input  logic [SLOT_BITS-1:0] slot_sel,
  input  logic                 frame_start,
  input  logic                 stall,
  output logic                 begin_save_state,
  output logic                 begin_load_state,
  output logic [SLOT_BITS-1:0] slot_addr,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic save_req, load_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_save_db (
    .clock (clock),
    .reset (reset),
    .btn   (save_btn),
    .req   (save_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clock (clock),
    .reset (reset),
    .btn   (load_btn),
    .req   (load_req)
  );

  ctrl_state_e          state_q, state_d;
  op_e                  op_q, op_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [TW-1:0]        tmo_q, tmo_d, tmo_inc;
  logic                 bsave_q, bsave_d;
  logic                 bload_q, bload_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    bsave_d = 1'b0;
    bload_d = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Save has priority; a coincident load is simply dropped.
        if (save_req) begin
          slot_d  = slot_sel;
          op_d    = OP_SAVE;
          state_d = ST_ARM;
        end else if (load_req) begin
          if (valid_q[slot_sel]) begin
            slot_d  = slot_sel;
            op_d    = OP_LOAD;
            state_d = ST_ARM;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        if (frame_start) begin
          bsave_d = (op_q == OP_SAVE);
          bload_d = (op_q == OP_LOAD);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (!stall) begin
          done_d  = 1'b1;
          if (op_q == OP_SAVE) valid_d[slot_q] = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_inc == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SAVE;
      slot_q  <= '0;
      valid_q <= '0;
      tmo_q   <= '0;
      bsave_q <= 1'b0;
      bload_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      bsave_q <= bsave_d;
      bload_q <= bload_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign begin_save_state = bsave_q;
  assign begin_load_state = bload_q;
  assign slot_addr        = slot_q;
  assign slot_valid       = valid_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_save_state_ctrl.sv
// Directed bench for save_state_ctrl: pulse events are scoreboarded against expected cycle/slot/valid.
module tb_save_state_ctrl;

  localparam int K_BSAVE = 0;
  localparam int K_BLOAD = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       save_btn, load_btn, frame_start, stall;
  logic [1:0] slot_sel;
  logic       begin_save_state, begin_load_state, busy, done, error;
  logic [1:0] slot_addr;
  logic [3:0] slot_valid;

  save_state_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .NUM_SLOTS       (4),
    .SLOT_BITS       (2),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .save_btn         (save_btn),
    .load_btn         (load_btn),
    .slot_sel         (slot_sel),
    .frame_start      (frame_start),
    .stall            (stall),
    .begin_save_state (begin_save_state),
    .begin_load_state (begin_load_state),
    .slot_addr        (slot_addr),
    .slot_valid       (slot_valid),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Engine stall model: high in the begin cycle, then for stall_len cycles (or forever).
  int stall_cnt = 0;
  int stall_len = 0;
  bit stall_forever = 1'b0;
  always @(posedge clock) begin
    if (begin_save_state || begin_load_state) stall_cnt <= stall_len;
    else if (stall_cnt > 0)                   stall_cnt <= stall_cnt - 1;
  end
  assign stall = begin_save_state | begin_load_state | (stall_cnt > 0) | stall_forever;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] slot;
    logic [3:0] valid;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  busy_rises = 0;
  bit  busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(input int kind, input int c, input logic [1:0] slot, input logic [3:0] valid);
    ev_t e;
    e.kind = kind; e.cyc = c; e.slot = slot; e.valid = valid;
    exp_q.push_back(e);
  endtask

  // cyc < 0 in an expectation means the exact cycle is not pinned down.
  task automatic check_events(input string tag);
    ev_t x, o;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      x = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_kind"}, o.kind, x.kind);
      if (x.cyc >= 0) chk({tag, "_cyc"}, o.cyc, x.cyc);
      chk({tag, "_slot"}, {30'd0, o.slot}, {30'd0, x.slot});
      chk({tag, "_valid"}, {28'd0, o.valid}, {28'd0, x.valid});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic press(input bit s, input bit l);
    save_btn = s; load_btn = l;
    tick(12);
    save_btn = 1'b0; load_btn = 1'b0;
    tick(12);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bsave"}, begin_save_state, 0);
    chk({tag, "_bload"}, begin_load_state, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_addr"},  {30'd0, slot_addr}, 0);
    chk({tag, "_valid"}, {28'd0, slot_valid}, 0);
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (busy && !busy_prev) busy_rises++;
    busy_prev = busy;
    if (begin_save_state || begin_load_state || done || error) begin
      chk("pulse_onehot", $countones({begin_save_state, begin_load_state, done, error}), 1);
      e.cyc = cyc; e.slot = slot_addr; e.valid = slot_valid;
      if (begin_save_state) begin e.kind = K_BSAVE; obs_q.push_back(e); end
      if (begin_load_state) begin e.kind = K_BLOAD; obs_q.push_back(e); end
      if (done)             begin e.kind = K_DONE;  obs_q.push_back(e); end
      if (error)            begin e.kind = K_ERR;   obs_q.push_back(e); end
    end
  end

  initial begin
    int f;
    reset = 1'b1; save_btn = 1'b0; load_btn = 1'b0; frame_start = 1'b0; slot_sel = 2'd0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Load of an empty slot: error only, never busy.
    busy_rises = 0;
    slot_sel = 2'd1;
    push_exp(K_ERR, -1, 2'd0, 4'd0);
    press(1'b0, 1'b1);
    chk("inv_load_busy_rises", busy_rises, 0);
    check_events("inv_load");

    // Bouncing save button followed by a stable press, then a full save to slot 2.
    busy_rises = 0;
    slot_sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      save_btn = (i % 2 == 0);
      tick(2);
    end
    save_btn = 1'b1;
    tick(10);
    save_btn = 1'b0;
    slot_sel = 2'd0;
    tick(12);
    chk("bounce_busy_rises", busy_rises, 1);
    chk("bounce_busy", busy, 1);
    stall_len = 30;
    f = cyc;
    frame_start = 1'b1;
    push_exp(K_BSAVE, f + 1, 2'd2, 4'b0000);
    push_exp(K_DONE, f + 33, 2'd2, 4'b0100);
    tick(1);
    frame_start = 1'b0;
    tick(15);
    chk("save_mid_addr", {30'd0, slot_addr}, 2);
    chk("save_mid_busy", busy, 1);
    tick(30);
    chk("save_valid", {28'd0, slot_valid}, 4'b0100);
    chk("save_idle", busy, 0);
    chk("save_addr_held", {30'd0, slot_addr}, 2);
    chk("save_busy_rises", busy_rises, 1);
    check_events("save");

    // Valid load of slot 2; slot_sel change and a save press mid-transfer are ignored.
    busy_rises = 0;
    slot_sel = 2'd2;
    press(1'b0, 1'b1);
    slot_sel = 2'd3;
    chk("load_busy", busy, 1);
    f = cyc;
    frame_start = 1'b1;
    push_exp(K_BLOAD, f + 1, 2'd2, 4'b0100);
    push_exp(K_DONE, f + 33, 2'd2, 4'b0100);
    tick(1);
    frame_start = 1'b0;
    tick(2);
    save_btn = 1'b1;
    tick(10);
    save_btn = 1'b0;
    tick(40);
    chk("load_busy_rises", busy_rises, 1);
    chk("load_addr", {30'd0, slot_addr}, 2);
    chk("load_valid", {28'd0, slot_valid}, 4'b0100);
    chk("load_idle", busy, 0);
    check_events("load");

    // Coincident save/load to empty slot 3: save wins, engine never finishes -> timeout.
    busy_rises = 0;
    slot_sel = 2'd3;
    stall_forever = 1'b1;
    press(1'b1, 1'b1);
    chk("tmo_busy", busy, 1);
    f = cyc;
    frame_start = 1'b1;
    push_exp(K_BSAVE, f + 1, 2'd3, 4'b0100);
    push_exp(K_ERR, f + 65, 2'd3, 4'b0100);
    tick(1);
    frame_start = 1'b0;
    tick(80);
    chk("tmo_idle", busy, 0);
    chk("tmo_valid", {28'd0, slot_valid}, 4'b0100);
    chk("tmo_busy_rises", busy_rises, 1);
    check_events("timeout");

    // Reset while waiting on the engine: everything clears, no completion pulse follows.
    slot_sel = 2'd1;
    press(1'b1, 1'b0);
    f = cyc;
    frame_start = 1'b1;
    push_exp(K_BSAVE, f + 1, 2'd1, 4'b0100);
    tick(1);
    frame_start = 1'b0;
    tick(10);
    chk("rst_mid_busy", busy, 1);
    reset = 1'b1;
    tick(1);
    chk_all_zero("rst_mid");
    reset = 1'b0;
    stall_forever = 1'b0;
    tick(80);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_valid", {28'd0, slot_valid}, 0);
    check_events("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
